// File: rtl/temp_bcd_format.sv
// DS18B20 raw temperature word to four seven-segment digit nibbles with decimal
// point and blanking masks; binary-to-BCD runs as shift-add-3, one bit per clock.
module temp_bcd_format #(
    parameter logic [3:0] P_NEG_CODE = 4'hD
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [15:0] i_raw,
    output logic        o_ready,
    output logic        o_done,
    output logic        o_err,
    output logic [15:0] o_data,
    output logic [3:0]  o_dp,
    output logic [3:0]  o_turn_off
);

    typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;

    state_t      state_q, state_d;
    logic        neg_q, neg_d;
    logic        err_q, err_d;
    logic [3:0]  frac_q, frac_d;
    logic [7:0]  sh_q, sh_d;
    logic [11:0] bcd_q, bcd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        oerr_q, oerr_d;
    logic [15:0] data_q, data_d;
    logic [3:0]  dp_q, dp_d;
    logic [3:0]  off_q, off_d;

    logic [15:0] mag;
    logic [11:0] int_w;
    logic [3:0]  frac_w;
    logic [7:0]  bcd_adj;
    logic [3:0]  dig_h, dig_t, dig_o;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [3:0] frac_digit(input logic [3:0] f);
        return 4'(({4'd0, f} * 8'd10) >> 4);
    endfunction

    assign mag     = i_raw[15] ? (~i_raw + 16'd1) : i_raw;
    assign int_w   = mag[15:4];
    assign frac_w  = frac_digit(mag[3:0]);
    // Hundreds never exceeds 2 within an 8-bit input, so only tens/ones need the +3 step.
    assign bcd_adj = {add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    assign dig_h   = bcd_q[11:8];
    assign dig_t   = bcd_q[7:4];
    assign dig_o   = bcd_q[3:0];

    always_comb begin
        state_d = state_q;
        neg_d   = neg_q;
        err_d   = err_q;
        frac_d  = frac_q;
        sh_d    = sh_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        oerr_d  = oerr_q;
        data_d  = data_q;
        dp_d    = dp_q;
        off_d   = off_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    neg_d   = i_raw[15];
                    err_d   = (int_w > 12'd199) || (i_raw[15] && (int_w > 12'd99));
                    frac_d  = frac_w;
                    sh_d    = int_w[7:0];
                    bcd_d   = '0;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = {bcd_q[10:8], bcd_adj, sh_q[7]};
                sh_d  = {sh_q[6:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd7) begin
                    state_d = FORMAT;
                end
            end
            FORMAT: begin
                state_d = IDLE;
                ready_d = 1'b1;
                done_d  = 1'b1;
                oerr_d  = err_q;
                if (err_q) begin
                    data_d = {4{P_NEG_CODE}};
                    dp_d   = 4'b0000;
                    off_d  = 4'b0000;
                end else begin
                    dp_d = 4'b0010;
                    if (neg_q) begin
                        // Minus sign sits immediately left of the most significant shown digit.
                        if (dig_t != 4'd0) begin
                            data_d = {P_NEG_CODE, dig_t, dig_o, frac_q};
                            off_d  = 4'b0000;
                        end else begin
                            data_d = {4'd0, P_NEG_CODE, dig_o, frac_q};
                            off_d  = 4'b1000;
                        end
                    end else if (dig_h != 4'd0) begin
                        data_d = {dig_h, dig_t, dig_o, frac_q};
                        off_d  = 4'b0000;
                    end else if (dig_t != 4'd0) begin
                        data_d = {4'd0, dig_t, dig_o, frac_q};
                        off_d  = 4'b1000;
                    end else begin
                        data_d = {8'd0, dig_o, frac_q};
                        off_d  = 4'b1100;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
            frac_q  <= '0;
            sh_q    <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            oerr_q  <= 1'b0;
            data_q  <= '0;
            dp_q    <= 4'b0000;
            off_q   <= 4'b1111;
        end else begin
            state_q <= state_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
            frac_q  <= frac_d;
            sh_q    <= sh_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            oerr_q  <= oerr_d;
            data_q  <= data_d;
            dp_q    <= dp_d;
            off_q   <= off_d;
        end
    end

    assign o_ready    = ready_q;
    assign o_done     = done_q;
    assign o_err      = oerr_q;
    assign o_data     = data_q;
    assign o_dp       = dp_q;
    assign o_turn_off = off_q;

endmodule

// File: tb/tb_temp_bcd_format.sv
// Bench for temp_bcd_format: directed vectors, random samples against an
// arithmetic reference, busy-drop, back-to-back and reset scenarios.
module tb_temp_bcd_format;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic [15:0] i_raw;
    logic        o_ready, o_done, o_err;
    logic [15:0] o_data;
    logic [3:0]  o_dp, o_turn_off;

    int n_cmp = 0;
    int n_bad = 0;

    temp_bcd_format dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_raw(i_raw),
        .o_ready(o_ready), .o_done(o_done), .o_err(o_err),
        .o_data(o_data), .o_dp(o_dp), .o_turn_off(o_turn_off)
    );

    always #5 i_clk = ~i_clk;

    function automatic void model(input logic [15:0] raw, output logic [15:0] d,
                                  output logic [3:0] dp, output logic [3:0] off,
                                  output logic e);
        int v, m, ip, fr, h, t, o;
        bit neg;
        v   = int'($signed(raw));
        neg = (v < 0);
        m   = neg ? -v : v;
        ip  = m / 16;
        fr  = ((m % 16) * 10) / 16;
        h   = ip / 100;
        t   = (ip / 10) % 10;
        o   = ip % 10;
        e   = (ip > 199) || (neg && ip > 99);
        if (e) begin
            d = 16'hDDDD; dp = 4'b0000; off = 4'b0000;
        end else begin
            dp = 4'b0010;
            if (neg && t != 0)      begin d = {4'hD, 4'(t), 4'(o), 4'(fr)}; off = 4'b0000; end
            else if (neg)           begin d = {4'h0, 4'hD, 4'(o), 4'(fr)};  off = 4'b1000; end
            else if (h != 0)        begin d = {4'(h), 4'(t), 4'(o), 4'(fr)}; off = 4'b0000; end
            else if (t != 0)        begin d = {4'h0, 4'(t), 4'(o), 4'(fr)};  off = 4'b1000; end
            else                    begin d = {8'h00, 4'(o), 4'(fr)};        off = 4'b1100; end
        end
    endfunction

    // Starts one conversion from idle and waits (bounded) for o_done; lat = edges after accept.
    task automatic run_conv(input logic [15:0] raw, output int lat);
        i_valid = 1'b1;
        i_raw   = raw;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_raw   = 16'($urandom);
        lat = 0;
        while (o_done !== 1'b1 && lat < 40) begin
            @(posedge i_clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_valid = 1'b0; i_raw = 16'h0000;
        #1;
        n_cmp++;
        if ({o_ready, o_done, o_err, o_data, o_dp, o_turn_off} !== {3'b100, 16'h0000, 4'b0000, 4'b1111}) begin
            n_bad++;
            $display("FAIL reset_vals: got rdy=%b done=%b err=%b data=%h dp=%b off=%b want 1 0 0 0000 0000 1111",
                     o_ready, o_done, o_err, o_data, o_dp, o_turn_off);
        end
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
    endtask

    typedef struct { logic [15:0] raw; logic [15:0] d; logic [3:0] off; logic e; } vec_t;

    task automatic test_directed();
        vec_t v [11];
        int lat;
        v[0]  = '{16'h0191, 16'h0250, 4'b1000, 1'b0};
        v[1]  = '{16'h0091, 16'h0090, 4'b1100, 1'b0};
        v[2]  = '{16'h07D0, 16'h1250, 4'b0000, 1'b0};
        v[3]  = '{16'hFC90, 16'hD550, 4'b0000, 1'b0};
        v[4]  = '{16'hFFF8, 16'h0D05, 4'b1000, 1'b0};
        v[5]  = '{16'h8000, 16'hDDDD, 4'b0000, 1'b1};
        v[6]  = '{16'h0C80, 16'hDDDD, 4'b0000, 1'b1};
        v[7]  = '{16'h0000, 16'h0000, 4'b1100, 1'b0};
        v[8]  = '{16'hFFFF, 16'h0D00, 4'b1000, 1'b0};
        v[9]  = '{16'h0C7F, 16'h1999, 4'b0000, 1'b0};
        v[10] = '{16'hF9C1, 16'hD999, 4'b0000, 1'b0};
        for (int i = 0; i < 11; i++) begin
            run_conv(v[i].raw, lat);
            n_cmp++;
            if (lat !== 9) begin
                n_bad++; $display("FAIL dir_latency raw=%h: got %0d want 9", v[i].raw, lat);
            end
            n_cmp++;
            if ({o_data, o_turn_off, o_err} !== {v[i].d, v[i].off, v[i].e}) begin
                n_bad++;
                $display("FAIL dir_out raw=%h: got data=%h off=%b err=%b want data=%h off=%b err=%b",
                         v[i].raw, o_data, o_turn_off, o_err, v[i].d, v[i].off, v[i].e);
            end
            n_cmp++;
            if (o_dp !== (v[i].e ? 4'b0000 : 4'b0010) || o_ready !== 1'b1) begin
                n_bad++; $display("FAIL dir_dp_ready raw=%h: got dp=%b rdy=%b", v[i].raw, o_dp, o_ready);
            end
            @(posedge i_clk); #1;
            n_cmp++;
            if (o_done !== 1'b0) begin
                n_bad++; $display("FAIL dir_done_width raw=%h: got done=%b want 0", v[i].raw, o_done);
            end
        end
        // -100.0 is the first negative value out of range
        run_conv(16'hF9C0, lat);
        n_cmp++;
        if (o_err !== 1'b1 || o_data !== 16'hDDDD) begin
            n_bad++; $display("FAIL dir_neg_range: got err=%b data=%h want 1 dddd", o_err, o_data);
        end
    endtask

    task automatic test_random();
        logic [15:0] raw, ed;
        logic [3:0]  edp, eoff;
        logic        ee;
        int lat;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 2))
                0: raw = 16'($urandom_range(0, 16'h0CFF));
                1: raw = 16'(-$urandom_range(0, 16'h0680));
                default: raw = 16'($urandom);
            endcase
            model(raw, ed, edp, eoff, ee);
            run_conv(raw, lat);
            n_cmp++;
            if (lat !== 9 || {o_data, o_dp, o_turn_off, o_err} !== {ed, edp, eoff, ee}) begin
                n_bad++;
                $display("FAIL rand raw=%h: got lat=%0d data=%h dp=%b off=%b err=%b want 9 %h %b %b %b",
                         raw, lat, o_data, o_dp, o_turn_off, o_err, ed, edp, eoff, ee);
            end
            @(posedge i_clk); #1;
        end
    endtask

    task automatic test_busy_drop();
        int lat, ndone, done_k, nlow;
        bit early;
        run_conv(16'h0000, lat);
        @(posedge i_clk); #1;
        i_valid = 1'b1; i_raw = 16'h0191;
        @(posedge i_clk); #1;
        nlow = (o_ready == 1'b0) ? 1 : 0;
        ndone = 0; done_k = -1; early = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            i_valid = (k == 3);
            i_raw   = (k == 3) ? 16'h07D0 : 16'h0000;
            @(posedge i_clk); #1;
            if (o_done) begin ndone++; done_k = k; end
            if (!o_ready) nlow++;
            if (k < 9 && o_data !== 16'h0000) early = 1'b1;
        end
        n_cmp++;
        if (ndone !== 1 || done_k !== 9) begin
            n_bad++; $display("FAIL busy_done: got count=%0d at=%0d want 1 at 9", ndone, done_k);
        end
        n_cmp++;
        if (o_data !== 16'h0250 || o_turn_off !== 4'b1000) begin
            n_bad++; $display("FAIL busy_data: got %h/%b want 0250/1000", o_data, o_turn_off);
        end
        n_cmp++;
        if (nlow !== 9) begin
            n_bad++; $display("FAIL busy_ready_low: got %0d cycles want 9", nlow);
        end
        n_cmp++;
        if (early) begin
            n_bad++; $display("FAIL busy_display_stable: got change before format want none");
        end
    endtask

    task automatic test_back_to_back();
        int d1, d2, nd;
        logic [15:0] first;
        logic        rdy10;
        i_valid = 1'b1; i_raw = 16'h0191;
        @(posedge i_clk); #1;
        i_raw = 16'hFC90;
        d1 = -1; d2 = -1; nd = 0; first = 16'h0; rdy10 = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(posedge i_clk); #1;
            if (k == 10) begin rdy10 = o_ready; i_valid = 1'b0; end
            if (o_done) begin
                nd++;
                if (d1 < 0) begin d1 = k; first = o_data; end else d2 = k;
            end
        end
        n_cmp++;
        if (nd !== 2 || d1 !== 9 || d2 !== 19 || rdy10 !== 1'b0) begin
            n_bad++; $display("FAIL b2b_timing: got n=%0d d1=%0d d2=%0d rdy10=%b want 2 9 19 0", nd, d1, d2, rdy10);
        end
        n_cmp++;
        if (first !== 16'h0250 || o_data !== 16'hD550) begin
            n_bad++; $display("FAIL b2b_data: got %h then %h want 0250 then d550", first, o_data);
        end
    endtask

    task automatic test_reset_mid();
        int lat, nd;
        bit bad_after;
        run_conv(16'h07D0, lat);
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        #1;
        n_cmp++;
        if ({o_ready, o_done, o_err, o_data, o_dp, o_turn_off} !== {3'b100, 16'h0000, 4'b0000, 4'b1111}) begin
            n_bad++; $display("FAIL reset_idle: got data=%h dp=%b off=%b rdy=%b", o_data, o_dp, o_turn_off, o_ready);
        end
        @(posedge i_clk); #1 i_rst = 1'b0;
        i_valid = 1'b1; i_raw = 16'h0191;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (4) @(posedge i_clk);
        #1 i_rst = 1'b1;
        #1;
        n_cmp++;
        if ({o_ready, o_done, o_err, o_data, o_dp, o_turn_off} !== {3'b100, 16'h0000, 4'b0000, 4'b1111}) begin
            n_bad++; $display("FAIL reset_shift: got data=%h dp=%b off=%b rdy=%b", o_data, o_dp, o_turn_off, o_ready);
        end
        @(posedge i_clk); #1 i_rst = 1'b0;
        nd = 0; bad_after = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(posedge i_clk); #1;
            if (o_done) nd++;
            if (o_turn_off !== 4'b1111 || o_data !== 16'h0000 || o_ready !== 1'b1) bad_after = 1'b1;
        end
        n_cmp++;
        if (nd !== 0 || bad_after) begin
            n_bad++; $display("FAIL reset_after: got done_count=%0d disturbed=%b want 0 0", nd, bad_after);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_drop();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
